// File: rtl/fp_normalize_round_if.sv
// fp_normalize_round_if: upstream operand and downstream result handshakes of the normalize/round stage
interface fp_normalize_round_if;
  logic inValid;
  logic inReady;
  logic [23:0] alignedResult;
  logic carryOut;
  logic alignedSign;
  logic [7:0] exponentOut;
  logic guardBit;
  logic roundBit;
  logic stickyBit;
  logic outValid;
  logic outReady;
  logic normalizedSign;
  logic [7:0] normalizedExponent;
  logic [22:0] normalizedMantissa;
  modport master (
    output inValid, alignedResult, carryOut, alignedSign, exponentOut, guardBit, roundBit, stickyBit, outReady,
    input inReady, outValid, normalizedSign, normalizedExponent, normalizedMantissa
  );
  modport slave (
    input inValid, alignedResult, carryOut, alignedSign, exponentOut, guardBit, roundBit, stickyBit, outReady,
    output inReady, outValid, normalizedSign, normalizedExponent, normalizedMantissa
  );
endinterface

// File: rtl/fp_normalize_round.sv
// fp_normalize_round: bit-serial normalize then round-to-nearest-even for the FP adder
// FP_NORM_FLUSH_DENORM_EN flushes denormal results to signed zero instead of gradual underflow
module fp_normalize_round (
  input logic clk,
  input logic reset,
  fp_normalize_round_if.slave bus
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t state, stateNext;
  logic [24:0] m, mNext, mRnd;
  logic [8:0] e, eNext, eRnd;
  logic g, r, s, sign, gNext, rNext, sNext, signNext, inc, done;
  assign done = state == DONE;
  assign bus.inReady = state == IDLE && !reset;
  assign bus.outValid = done;
  assign bus.normalizedSign = done & sign;
  assign bus.normalizedExponent = done ? e[7:0] : '0;
  assign bus.normalizedMantissa = done ? m[22:0] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      m <= '0;
      e <= '0;
      g <= 1'b0;
      r <= 1'b0;
      s <= 1'b0;
      sign <= 1'b0;
    end else begin
      state <= stateNext;
      m <= mNext;
      e <= eNext;
      g <= gNext;
      r <= rNext;
      s <= sNext;
      sign <= signNext;
    end
  end
  always_comb begin
    stateNext = state;
    mNext = m;
    eNext = e;
    gNext = g;
    rNext = r;
    sNext = s;
    signNext = sign;
    inc = g & (r | s | m[0]);
    mRnd = m + {24'd0, inc};
    eRnd = e;
    if (mRnd[24]) begin
      mRnd = mRnd >> 1;
      eRnd = e + 9'd1;
    end
    // a denormal that rounds up into the hidden bit becomes the smallest normal
    if (eRnd == 9'd0 && mRnd[23]) eRnd = 9'd1;
    if (eRnd >= 9'd255) begin
      eRnd = 9'd255;
      mRnd = '0;
    end
    unique case (state)
      IDLE: if (bus.inValid) begin
        mNext = {bus.carryOut, bus.alignedResult};
        eNext = {1'b0, bus.exponentOut};
        gNext = bus.guardBit;
        rNext = bus.roundBit;
        sNext = bus.stickyBit;
        signNext = bus.alignedSign;
        stateNext = NORM;
      end
      NORM: if (m == '0 && !(g | r | s)) begin
        eNext = '0;
        stateNext = DONE;
      end else if (m[24]) begin
        mNext = m >> 1;
        gNext = m[0];
        rNext = g;
        sNext = s | r;
        eNext = e + 9'd1;
      end else if (!m[23] && e > 9'd1) begin
        mNext = {m[23:0], g};
        gNext = r;
        rNext = 1'b0;
        eNext = e - 9'd1;
      end else if (!m[23]) begin
`ifdef FP_NORM_FLUSH_DENORM_EN
        eNext = '0;
        mNext = '0;
        gNext = 1'b0;
        rNext = 1'b0;
        sNext = 1'b0;
        stateNext = DONE;
`else
        eNext = '0;
        stateNext = ROUND;
`endif
      end else stateNext = ROUND;
      ROUND: begin
        mNext = mRnd;
        eNext = eRnd;
        stateNext = DONE;
      end
      DONE: if (bus.outReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round: directed scoreboard bench for fp_normalize_round
module tb_fp_normalize_round;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic sign;
    logic [7:0] exp;
    logic [22:0] mant;
    int cyc;
  } want_t;
  want_t scoreboard[$];
`ifdef FP_NORM_FLUSH_DENORM_EN
  localparam logic [22:0] denMant = 23'h0;
  localparam int denCyc = 2;
  localparam logic [7:0] denUpExp = 8'h00;
  localparam int denUpCyc = 2;
`else
  localparam logic [22:0] denMant = 23'h400000;
  localparam int denCyc = 3;
  localparam logic [7:0] denUpExp = 8'h01;
  localparam int denUpCyc = 3;
`endif
  fp_normalize_round_if bus();
  fp_normalize_round dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic [23:0] ar, input logic c, input logic sg, input logic [7:0] ex,
                       input logic gIn, input logic rIn, input logic sIn);
    bus.alignedResult = ar;
    bus.carryOut = c;
    bus.alignedSign = sg;
    bus.exponentOut = ex;
    bus.guardBit = gIn;
    bus.roundBit = rIn;
    bus.stickyBit = sIn;
    bus.inValid = 1'b1;
  endtask

  task automatic runOp(input string tag, input logic [23:0] ar, input logic c, input logic sg,
                       input logic [7:0] ex, input logic gIn, input logic rIn, input logic sIn,
                       input logic wSign, input logic [7:0] wExp, input logic [22:0] wMant,
                       input int wCyc, input int hold);
    want_t w;
    int edges;
    logic readySeen;
    scoreboard.push_back('{wSign, wExp, wMant, wCyc});
    @(negedge clk);
    check({tag, "/inReady"}, 32'(bus.inReady), 32'd1);
    bus.outReady = (hold == 0);
    drive(ar, c, sg, ex, gIn, rIn, sIn);
    @(posedge clk);
    #1 bus.inValid = 1'b0;
    edges = 0;
    readySeen = 1'b0;
    while (!bus.outValid && edges < 40) begin
      readySeen |= bus.inReady;
      @(posedge clk);
      #1 edges++;
    end
    readySeen |= bus.inReady;
    w = scoreboard.pop_front();
    check({tag, "/outValid"}, 32'(bus.outValid), 32'd1);
    check({tag, "/cycle"}, 32'(edges + 1), 32'(w.cyc));
    check({tag, "/sign"}, 32'(bus.normalizedSign), 32'(w.sign));
    check({tag, "/exp"}, 32'(bus.normalizedExponent), 32'(w.exp));
    check({tag, "/mant"}, 32'(bus.normalizedMantissa), 32'(w.mant));
    check({tag, "/busyInReady"}, 32'(readySeen), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 check({tag, "/held"},
               {bus.outValid, bus.inReady, bus.normalizedSign, bus.normalizedExponent, bus.normalizedMantissa},
               {1'b1, 1'b0, w.sign, w.exp, w.mant});
    end
    bus.outReady = 1'b1;
    @(posedge clk);
    #1 check({tag, "/release"}, 32'(bus.outValid), 32'd0);
  endtask

  initial begin
    logic seenValid;
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    drive(24'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
    bus.inValid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/outs", {bus.outValid, bus.inReady, bus.normalizedSign, bus.normalizedExponent, bus.normalizedMantissa}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset/inReadyAfter", 32'(bus.inReady), 32'd1);
    runOp("one", 24'h800000, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 23'h0, 3, 0);
    runOp("carry", 24'h000000, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 23'h0, 4, 0);
    runOp("carryInf", 24'h000000, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 23'h0, 4, 0);
    runOp("carryRound", 24'h000003, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 23'h2, 4, 0);
    runOp("cancel", 24'h000001, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'h69, 23'h0, 26, 0);
    runOp("shiftInG", 24'h400000, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E, 23'h1, 4, 0);
    runOp("rneOvf", 24'hFFFFFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 23'h0, 3, 0);
    runOp("tieEven", 24'h800000, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 23'h0, 3, 0);
    runOp("tieOdd", 24'h800001, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 23'h2, 3, 0);
    runOp("sticky", 24'h800000, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7F, 23'h1, 3, 0);
    runOp("denorm", 24'h400000, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, denMant, denCyc, 0);
    runOp("denormUp", 24'h7FFFFF, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, denUpExp, 23'h0, denUpCyc, 0);
    runOp("zero", 24'h000000, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 23'h0, 2, 0);
    runOp("backpressure", 24'h800000, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 23'h0, 3, 5);
    @(negedge clk);
    drive(24'h000001, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.inValid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 check("abort/outs", {bus.outValid, bus.inReady, bus.normalizedSign, bus.normalizedExponent, bus.normalizedMantissa}, 32'd0);
    @(negedge clk) reset = 1'b0;
    #1 check("abort/inReady", 32'(bus.inReady), 32'd1);
    seenValid = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1 seenValid |= bus.outValid;
    end
    check("abort/noResult", 32'(seenValid), 32'd0);
    runOp("recover", 24'h800000, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 23'h0, 3, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_normalize_round.md
# fp_normalize_round

Multi-cycle normalize-and-round stage of the FP adder datapath. It sits directly downstream of the ALU stage and consumes its aligned sum, carry, sign, exponent and guard/round/sticky bits. It produces the normalized sign, exponent and 23-bit mantissa that feed the pack stage. Normalization shifts one bit per cycle under a small FSM, followed by round-to-nearest-even; valid/ready handshakes on both sides.

## Interface
Parameters: none (IEEE-754 single precision fixed).

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- inValid  input  1  upstream operands valid
- inReady  output  1  stage can accept; = (state==IDLE) && !reset
- alignedResult  input  24  ALU magnitude, bit 23 = hidden-bit position
- carryOut  input  1  ALU carry above bit 23
- alignedSign  input  1  result sign from ALU
- exponentOut  input  8  biased common exponent from align stage
- guardBit, roundBit, stickyBit  input  1 each  bits shifted out during alignment
- outValid  output  1  result valid; reset 0
- outReady  input  1  pack stage accepts
- normalizedSign  output  1  reset 0
- normalizedExponent  output  8  reset 0
- normalizedMantissa  output  23  fraction without hidden bit; reset 0

## Operation
- Internal regs: m[24:0], e[8:0] (9-bit for overflow detection), g, r, s, sign, state.
- States: IDLE, NORM, ROUND, DONE. Reset -> IDLE, all regs and outputs 0.
- IDLE: on inValid&&inReady capture m={carryOut,alignedResult}, e={0,exponentOut}, g/r/s, sign; -> NORM.
- NORM, priority order, one action per cycle:
  - m==0 && g==r==s==0: e=0, signed zero (sign kept); -> DONE.
  - m[24]: right shift: m>>=1, g<=m[0], r<=g, s<=s|r, e+=1; stay NORM.
  - !m[23] && e>1: left shift: m={m[23:0],g}, g<=r, r<=0, s unchanged, e-=1; stay NORM.
  - !m[23] && e<=1: denormal, e=0; -> ROUND.
  - else -> ROUND.
- ROUND: inc = g & (r|s|m[0]); m+=inc. If m[24] after increment: m>>=1, e+=1. If e==0 and m[23]==1 after increment: e=1. If e>=255: e=255, m=0 (signed infinity). -> DONE.
- DONE: outputs driven from regs (normalizedMantissa=m[22:0], normalizedExponent=e[7:0]); outValid=1; held stable until outReady; on outValid&&outReady -> IDLE.
- inReady low in NORM/ROUND/DONE; no new capture until DONE handshake completes.
- Reset asserted in any state aborts in-flight operation: next cycle IDLE, outValid 0, outputs 0.
- NaN/Inf inputs are not handled here (upstream bypass).

## Timing
- Handshake at edge 0. Normalized input (m[23]=1, no carry): outValid at cycle 3. Carry: cycle 4. k left shifts: cycle 3+k; max 26 (k=23). Zero result: cycle 2.
- Throughput: one op per latency+1 cycles (DONE->IDLE takes one cycle); no back-to-back overlap.
- outValid with outReady low: outputs frozen indefinitely.

## Configuration
- FP_NORM_FLUSH_DENORM_EN defined: in NORM, denormal case (!m[23] && e<=1) produces signed zero (e=0, m=0) and goes straight to DONE, skipping ROUND.
- Undefined: gradual underflow as described above (ROUND applied, e=0 fraction kept).

## Test plan
- 1.0: alignedResult=24'h800000, carry 0, exp 8'h7F, g/r/s 0 -> exp 7F, mant 0, outValid at cycle 3.
- Carry: carryOut=1, alignedResult=0, exp 7F -> exp 80, mant 0 at cycle 4; with exp FE -> exp FF, mant 0 (infinity).
- Cancellation shift: alignedResult=24'h000001, exp 8'h80 -> exp 8'h69, mant 0, outValid at cycle 26; inReady low throughout.
- RNE with mantissa overflow: alignedResult=24'hFFFFFF, g=1, r=s=0, exp 7F -> exp 80, mant 0. Tie with even LSB: alignedResult=24'h800000, g=1 -> mant 0 (no increment).
- Denormal: alignedResult=24'h400000, exp 01 -> macro off: exp 00, mant 23'h400000; macro on: exp 00, mant 0. All-zero input, sign 1 -> sign 1, exp 0, mant 0 at cycle 2.
- Backpressure/reset: hold outReady low 5 cycles in DONE -> outputs stable, inReady 0; assert reset mid-NORM -> next cycle IDLE, outValid 0, inReady 1 after reset deasserts.
